// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with registered reads, write-to-read bypass,
// optional hardwired zero register and per-entry written tracking.
module register_file_mp #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 3,
  parameter int unsigned NUM_WRITE  = 2,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_WRITE-1:0]             wr_en_i,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wr_addr_i,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data_i,
  input  logic [NUM_READ-1:0]              rd_en_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data_o,
  output logic [NUM_READ-1:0]              rd_valid_o,
  output logic [NUM_READ-1:0]              rd_written_o,
  input  logic                             clear_i
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  data_t            mem_q [Depth];
  data_t            mem_d [Depth];
  logic [Depth-1:0] written_q, written_d;

  data_t               rd_data_q [NUM_READ];
  data_t               rd_data_d [NUM_READ];
  logic [NUM_READ-1:0] rd_valid_q, rd_valid_d;
  logic [NUM_READ-1:0] rd_written_q, rd_written_d;

  addr_t wr_addr [NUM_WRITE];
  data_t wr_data [NUM_WRITE];
  addr_t rd_addr [NUM_READ];

  for (genvar i = 0; i < NUM_WRITE; i++) begin : g_wr_unpack
    assign wr_addr[i] = wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data[i] = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar j = 0; j < NUM_READ; j++) begin : g_rd_unpack
    assign rd_addr[j]                           = rd_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_data_o[j*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[j];
  end

  assign rd_valid_o   = rd_valid_q;
  assign rd_written_o = rd_written_q;

  // Ascending port order makes the highest-index enabled port win on address conflicts.
  always_comb begin
    mem_d     = mem_q;
    written_d = clear_i ? '0 : written_q;
    for (int unsigned i = 0; i < NUM_WRITE; i++) begin
      if (wr_en_i[i] && !(ZERO_REG && (wr_addr[i] == '0))) begin
        mem_d[wr_addr[i]]     = wr_data[i];
        written_d[wr_addr[i]] = 1'b1;
      end
    end
  end

  // Bypass reads the post-write view; otherwise the pre-write (read-before-write) view.
  always_comb begin
    rd_data_d    = rd_data_q;
    rd_valid_d   = '0;
    rd_written_d = rd_written_q;
    for (int unsigned j = 0; j < NUM_READ; j++) begin
      if (rd_en_i[j]) begin
        rd_valid_d[j] = 1'b1;
        if (ZERO_REG && (rd_addr[j] == '0)) begin
          rd_data_d[j]    = '0;
          rd_written_d[j] = 1'b0;
        end else if (BYPASS) begin
          rd_data_d[j]    = mem_d[rd_addr[j]];
          rd_written_d[j] = written_d[rd_addr[j]];
        end else begin
          rd_data_d[j]    = mem_q[rd_addr[j]];
          rd_written_d[j] = written_q[rd_addr[j]];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q        <= '{default: '0};
      written_q    <= '0;
      rd_data_q    <= '{default: '0};
      rd_valid_q   <= '0;
      rd_written_q <= '0;
    end else begin
      mem_q        <= mem_d;
      written_q    <= written_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_written_q <= rd_written_d;
    end
  end

endmodule
